// File: rtl/rvc_pkg.sv
// Shared RV32/RVC encodings, state type and output payload for the RVC packer.
package rvc_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CLEN = 16;
  localparam int unsigned SLEN = 4;

  // RV32 major opcodes
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] JALR   = 7'h67;

  // RV32 funct3 values used by the compressible forms
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;

  // RVC quadrants
  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;

  // RVC funct3 values
  localparam logic [2:0] CF3_ADDI4SPN = 3'b000;
  localparam logic [2:0] CF3_LW       = 3'b010;
  localparam logic [2:0] CF3_SW       = 3'b110;
  localparam logic [2:0] CF3_ADDI     = 3'b000;
  localparam logic [2:0] CF3_LI       = 3'b010;
  localparam logic [2:0] CF3_SLLI     = 3'b000;
  localparam logic [2:0] CF3_LWSP     = 3'b010;
  localparam logic [2:0] CF3_SWSP     = 3'b110;
  localparam logic [2:0] CF3_CR       = 3'b100;

  localparam logic [CLEN-1:0] C_NOP = 16'h0001;

  localparam logic [SLEN-1:0] WSTRB_FULL = 4'b1111;
  localparam logic [SLEN-1:0] WSTRB_LO   = 4'b0011;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [SLEN-1:0] wstrb;
  } out_word_t;

  // Register is one of x8..x15 (3-bit RVC register field)
  function automatic logic is_creg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

  // 12-bit immediate fits a signed 6-bit field
  function automatic logic fits_simm6(input logic [11:0] imm);
    return (imm[11:5] == 7'h00) || (imm[11:5] == 7'h7F);
  endfunction

endpackage

// File: rtl/rvc_packer_if.sv
// Instruction-in / packed-word-out stream bundle for the RVC packer.
interface rvc_packer_if;

  logic                       in_valid;
  logic                       in_ready;
  logic [rvc_pkg::XLEN-1:0]   in_insn;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [rvc_pkg::XLEN-1:0]   out_data;
  logic [rvc_pkg::SLEN-1:0]   out_wstrb;

  modport slave (
    input  in_valid, in_insn, in_last, out_ready,
    output in_ready, out_valid, out_data, out_wstrb
  );

  modport master (
    output in_valid, in_insn, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_wstrb
  );

endinterface

// File: rtl/rvc_compress.sv
// Combinational RV32I -> RVC re-encoder; is_c flags a valid 16-bit parcel.
module rvc_compress
  import rvc_pkg::*;
#(
  parameter bit COMPRESSED_ISA = 1'b1
) (
  input  logic [XLEN-1:0] insn,
  output logic            is_c,
  output logic [CLEN-1:0] c16
);

  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic        hit;
  logic [CLEN-1:0] enc;

  // Match the compressible forms in priority order and build the parcel
  always_comb begin
    opc   = insn[6:0];
    rd    = insn[11:7];
    f3    = insn[14:12];
    rs1   = insn[19:15];
    rs2   = insn[24:20];
    f7    = insn[31:25];
    imm_i = insn[31:20];
    imm_s = {insn[31:25], insn[11:7]};
    hit   = 1'b0;
    enc   = '0;

    if (opc == OP_IMM && f3 == F3_ADD && rd != 5'd0 && rs1 == 5'd0 && fits_simm6(imm_i)) begin
      hit = 1'b1;
      enc = {CF3_LI, imm_i[5], rd, imm_i[4:0], Q1};
    end else if (opc == OP_IMM && f3 == F3_ADD && rd != 5'd0 && rs1 == rd &&
                 imm_i != 12'd0 && fits_simm6(imm_i)) begin
      hit = 1'b1;
      enc = {CF3_ADDI, imm_i[5], rd, imm_i[4:0], Q1};
    end else if (opc == OP_IMM && f3 == F3_ADD && is_creg(rd) && rs1 == 5'd2 &&
                 imm_i[11:10] == 2'b00 && imm_i[1:0] == 2'b00 && imm_i[9:2] != 8'd0) begin
      hit = 1'b1;
      enc = {CF3_ADDI4SPN, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], Q0};
    end else if (opc == LOAD && f3 == F3_W && is_creg(rd) && is_creg(rs1) &&
                 imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00) begin
      hit = 1'b1;
      enc = {CF3_LW, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], Q0};
    end else if (opc == STORE && f3 == F3_W && is_creg(rs2) && is_creg(rs1) &&
                 imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'b00) begin
      hit = 1'b1;
      enc = {CF3_SW, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], Q0};
    end else if (opc == LOAD && f3 == F3_W && rd != 5'd0 && rs1 == 5'd2 &&
                 imm_i[11:8] == 4'd0 && imm_i[1:0] == 2'b00) begin
      hit = 1'b1;
      enc = {CF3_LWSP, imm_i[5], rd, imm_i[4:2], imm_i[7:6], Q2};
    end else if (opc == STORE && f3 == F3_W && rs1 == 5'd2 &&
                 imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'b00) begin
      hit = 1'b1;
      enc = {CF3_SWSP, imm_s[5:2], imm_s[7:6], rs2, Q2};
    end else if (opc == OP_IMM && f3 == F3_SLL && f7 == 7'd0 && rd != 5'd0 &&
                 rs1 == rd && rs2 != 5'd0) begin
      hit = 1'b1;
      enc = {CF3_SLLI, 1'b0, rd, rs2, Q2};
    end else if (opc == OP && f3 == F3_ADD && f7 == 7'd0 && rd != 5'd0 &&
                 rs1 == 5'd0 && rs2 != 5'd0) begin
      hit = 1'b1;
      enc = {CF3_CR, 1'b0, rd, rs2, Q2};
    end else if (opc == OP && f3 == F3_ADD && f7 == 7'd0 && rd != 5'd0 &&
                 rs1 == rd && rs2 != 5'd0) begin
      hit = 1'b1;
      enc = {CF3_CR, 1'b1, rd, rs2, Q2};
    end else if (opc == JALR && f3 == 3'b000 && rd == 5'd0 && rs1 != 5'd0 &&
                 imm_i == 12'd0) begin
      hit = 1'b1;
      enc = {CF3_CR, 1'b0, rs1, 5'd0, Q2};
    end

    is_c = COMPRESSED_ISA && hit;
    c16  = enc;
  end

endmodule

// File: rtl/rvc_packer.sv
// Compresses an RV32I instruction stream and packs parcels into 32-bit code words.
module rvc_packer
  import rvc_pkg::*;
#(
  parameter bit              COMPRESSED_ISA = 1'b1,
  parameter logic [CLEN-1:0] C_NOP_PAD      = C_NOP
) (
  input  logic             clk,
  input  logic             resetn,
  rvc_packer_if.slave      io,
  output logic [XLEN-1:0]  count_in,
  output logic [XLEN-1:0]  count_comp
);

  state_e          state_q, state_d;
  logic [CLEN-1:0] hold_q, hold_d;
  logic            hold_v_q, hold_v_d;
  out_word_t       out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] count_in_q, count_in_d;
  logic [XLEN-1:0] count_comp_q, count_comp_d;

  logic            is_c;
  logic [CLEN-1:0] c16;
  logic            out_free;
  logic            in_ready_c;
  logic            accept;

  rvc_compress #(
    .COMPRESSED_ISA(COMPRESSED_ISA)
  ) u_compress (
    .insn (io.in_insn),
    .is_c (is_c),
    .c16  (c16)
  );

  // Next-state: flush beat, hold-buffer packing and counters
  always_comb begin
    out_free     = !out_valid_q || io.out_ready;
    in_ready_c   = (state_q == RUN) && out_free;
    accept       = io.in_valid && in_ready_c;
    state_d      = state_q;
    hold_d       = hold_q;
    hold_v_d     = hold_v_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q && !io.out_ready;
    count_in_d   = count_in_q;
    count_comp_d = count_comp_q;

    if (state_q == FLUSH) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_d.data  = {C_NOP_PAD, hold_q};
        out_d.wstrb = WSTRB_LO;
        hold_v_d    = 1'b0;
        state_d     = RUN;
      end
    end else if (accept) begin
      count_in_d = count_in_q + 32'd1;
      if (is_c) begin
        count_comp_d = count_comp_q + 32'd1;
      end
      case ({hold_v_q, is_c})
        2'b01: begin
          if (io.in_last) begin
            out_valid_d = 1'b1;
            out_d.data  = {C_NOP_PAD, c16};
            out_d.wstrb = WSTRB_LO;
          end else begin
            hold_d   = c16;
            hold_v_d = 1'b1;
          end
        end
        2'b00: begin
          out_valid_d = 1'b1;
          out_d.data  = io.in_insn;
          out_d.wstrb = WSTRB_FULL;
        end
        2'b11: begin
          out_valid_d = 1'b1;
          out_d.data  = {c16, hold_q};
          out_d.wstrb = WSTRB_FULL;
          hold_v_d    = 1'b0;
        end
        default: begin
          // Misaligned 32-bit: low half completes this word, high half is held
          out_valid_d = 1'b1;
          out_d.data  = {io.in_insn[15:0], hold_q};
          out_d.wstrb = WSTRB_FULL;
          hold_d      = io.in_insn[31:16];
          if (io.in_last) begin
            state_d = FLUSH;
          end
        end
      endcase
    end
  end

  // State, hold buffer, output register and counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= RUN;
      hold_q       <= '0;
      hold_v_q     <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      count_in_q   <= '0;
      count_comp_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_v_q     <= hold_v_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      count_in_q   <= count_in_d;
      count_comp_q <= count_comp_d;
    end
  end

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_q.data;
  assign io.out_wstrb = out_q.wstrb;
  assign count_in     = count_in_q;
  assign count_comp   = count_comp_q;

endmodule

// File: tb/tb_rvc_packer.sv
// Directed and random scoreboard bench for rvc_packer.
module tb_rvc_packer;
  import rvc_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] count_in;
  logic [31:0] count_comp;

  rvc_packer_if ifc ();

  rvc_packer #(
    .COMPRESSED_ISA(1'b1),
    .C_NOP_PAD     (16'h0001)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .io        (ifc.slave),
    .count_in  (count_in),
    .count_comp(count_comp)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          chk_mode = 0;   // 0: exact word scoreboard, 1: parcel/expansion scoreboard
  int          rdy_mode = 0;   // 0: ready, 1: stalled, 2: random
  logic [35:0] wq[$];          // {data, wstrb}
  logic [32:0] pq[$];          // {compressed, insn}
  logic [31:0] exp_in = 0;
  logic [31:0] exp_comp = 0;
  logic        have_pend = 1'b0;
  logic [15:0] pend_lo = 16'h0;
  logic [35:0] e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] stype(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  // Reference RVC expander for the parcel forms the packer may produce
  function automatic logic [31:0] expand(input logic [15:0] c);
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6, off;
    logic [31:0] r;
    rd   = c[11:7];
    rs2  = c[6:2];
    rdp  = {2'b01, c[4:2]};
    rs1p = {2'b01, c[9:7]};
    imm6 = {{6{c[12]}}, c[12], c[6:2]};
    r    = 32'h0;
    case ({c[15:13], c[1:0]})
      5'b000_00: begin
        off = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
        r = itype(off, 5'd2, 3'd0, rdp, 7'h13);
      end
      5'b010_00: begin
        off = {5'b0, c[5], c[12:10], c[6], 2'b00};
        r = itype(off, rs1p, 3'd2, rdp, 7'h03);
      end
      5'b110_00: begin
        off = {5'b0, c[5], c[12:10], c[6], 2'b00};
        r = stype(off, rdp, rs1p, 3'd2, 7'h23);
      end
      5'b000_01: r = itype(imm6, rd, 3'd0, rd, 7'h13);
      5'b010_01: r = itype(imm6, 5'd0, 3'd0, rd, 7'h13);
      5'b000_10: r = itype({7'b0, rs2}, rd, 3'd1, rd, 7'h13);
      5'b010_10: begin
        off = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
        r = itype(off, 5'd2, 3'd2, rd, 7'h03);
      end
      5'b110_10: begin
        off = {4'b0, c[8:7], c[12:9], 2'b00};
        r = stype(off, rs2, 5'd2, 3'd2, 7'h23);
      end
      5'b100_10: begin
        if (c[12]) r = rtype(7'd0, rs2, rd, rd);
        else if (rs2 == 5'd0) r = itype(12'd0, rd, 3'd0, 5'd0, 7'h67);
        else r = rtype(7'd0, rs2, 5'd0, rd);
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Random instruction from a template, in or just outside its compressible range
  task automatic gen(output logic [31:0] insn, output logic c);
    int          k  = $urandom_range(0, 11);
    logic        ok = ($urandom_range(0, 3) != 0);
    logic [4:0]  rd = 5'($urandom_range(1, 31));
    logic [4:0]  r2 = 5'($urandom_range(1, 31));
    logic [4:0]  pa = 5'($urandom_range(8, 15));
    logic [4:0]  pb = 5'($urandom_range(8, 15));
    logic [11:0] v;
    c = ok;
    case (k)
      0: begin
        v = ok ? 12'($urandom_range(0, 63)) - 12'd32 : 12'($urandom_range(32, 2000));
        insn = itype(v, 5'd0, 3'd0, rd, 7'h13);
      end
      1: begin
        v = 12'($urandom_range(0, 62));
        v = (v < 12'd32) ? v - 12'd32 : v - 12'd31;
        insn = itype(ok ? v : 12'd0, rd, 3'd0, rd, 7'h13);
      end
      2: begin
        v = ok ? 12'(4 * $urandom_range(1, 255)) : 12'(4 * $urandom_range(1, 254) + 2);
        insn = itype(v, 5'd2, 3'd0, pa, 7'h13);
      end
      3: begin
        v = ok ? 12'(4 * $urandom_range(0, 31)) : 12'(128 + 4 * $urandom_range(0, 200));
        insn = itype(v, pb, 3'd2, pa, 7'h03);
      end
      4: begin
        v = ok ? 12'(4 * $urandom_range(0, 31)) : 12'(128 + 4 * $urandom_range(0, 200));
        insn = stype(v, pa, pb, 3'd2, 7'h23);
      end
      5: begin
        v = ok ? 12'(4 * $urandom_range(0, 63)) : 12'(256 + 4 * $urandom_range(0, 100));
        insn = itype(v, 5'd2, 3'd2, rd, 7'h03);
      end
      6: begin
        v = ok ? 12'(4 * $urandom_range(0, 63)) : 12'(4 * $urandom_range(0, 62) + 1);
        insn = stype(v, 5'($urandom_range(0, 31)), 5'd2, 3'd2, 7'h23);
      end
      7: insn = itype({7'b0, ok ? r2 : 5'd0}, rd, 3'd1, rd, 7'h13);
      8: insn = rtype(7'd0, ok ? r2 : 5'd0, 5'd0, rd);
      9: insn = rtype(ok ? 7'd0 : 7'h20, r2, rd, rd);
      10: insn = itype(ok ? 12'd0 : 12'd4, rd, 3'd0, 5'd0, 7'h67);
      default: begin
        c = 1'b0;
        insn = {20'($urandom), rd, 7'h37};
      end
    endcase
  endtask

  // Consume one halfword of the output stream and match it to the next instruction
  task automatic take_half(input logic [15:0] h);
    logic [32:0] p;
    if (!have_pend && h[1:0] == 2'b11) begin
      pend_lo   = h;
      have_pend = 1'b1;
    end else if (pq.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL unexpected_parcel: observed %h expected none", h);
    end else begin
      p = pq.pop_front();
      if (have_pend) begin
        chk("insn32", {h, pend_lo}, p[31:0]);
        chk("was_compressed", 32'(1'b0), 32'(p[32]));
        have_pend = 1'b0;
      end else begin
        chk("expand", expand(h), p[31:0]);
        chk("was_compressed", 32'(1'b1), 32'(p[32]));
      end
    end
  endtask

  // Output monitor: every accepted word is checked against the scoreboard
  always @(negedge clk) begin
    if (resetn && ifc.out_valid && ifc.out_ready) begin
      if (chk_mode == 0) begin
        if (wq.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL unexpected_word: observed %h expected none", ifc.out_data);
        end else begin
          e = wq.pop_front();
          chk("out_data", ifc.out_data, e[35:4]);
          chk("out_wstrb", 32'(ifc.out_wstrb), 32'(e[3:0]));
        end
      end else begin
        take_half(ifc.out_data[15:0]);
        if (ifc.out_wstrb == 4'b1111) begin
          take_half(ifc.out_data[31:16]);
        end else begin
          chk("pad_half", 32'(ifc.out_data[31:16]), 32'h0001);
          chk("pad_wstrb", 32'(ifc.out_wstrb), 32'h3);
        end
      end
    end
  end

  // Output-ready driver
  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: ifc.out_ready = 1'b1;
        1: ifc.out_ready = 1'b0;
        default: ifc.out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] insn, input logic last);
    int n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_insn  = insn;
    ifc.in_last  = last;
    @(negedge clk);
    while (!ifc.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    assert (ifc.in_ready) else begin
      miscompares++;
      $error("FAIL accept_timeout: observed in_ready %b expected 1", ifc.in_ready);
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((wq.size() != 0 || pq.size() != 0 || ifc.out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    assert (n < 500) else begin
      miscompares++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", wq.size() + pq.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic [3:0] s);
    wq.push_back({d, s});
  endtask

  initial begin
    logic [31:0] insn;
    logic        c;
    logic        last;

    ifc.in_valid = 1'b0;
    ifc.in_insn  = 32'h0;
    ifc.in_last  = 1'b0;

    // Reset values
    #12;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
    chk("rst_out_data", ifc.out_data, 32'h0);
    chk("rst_out_wstrb", 32'(ifc.out_wstrb), 32'h0);
    chk("rst_count_in", count_in, 32'h0);
    chk("rst_count_comp", count_comp, 32'h0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'h1);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Pair of compressed instructions packs into one word
    push_word(32'h852E4515, 4'b1111);
    send(32'h00500513, 1'b0);
    send(32'h00B00533, 1'b0);
    exp_in += 2; exp_comp += 2;
    drain();
    chk("pair_count_comp", count_comp, exp_comp);
    chk("pair_count_in", count_in, exp_in);

    // Misaligned 32-bit instruction with in_last forces a flush beat
    push_word(32'h52B74515, 4'b1111);
    push_word(32'h00011234, 4'b0011);
    send(32'h00500513, 1'b0);
    send(32'h123452B7, 1'b1);
    chk("flush_in_ready", 32'(ifc.in_ready), 32'h0);
    exp_in += 2; exp_comp += 1;
    drain();

    // Aligned pass-through and an out-of-range addi
    push_word(32'h123452B7, 4'b1111);
    send(32'h123452B7, 1'b1);
    push_word(32'h02000513, 4'b1111);
    send(32'h02000513, 1'b1);
    exp_in += 2;
    drain();
    chk("passthru_count_comp", count_comp, exp_comp);

    // Lone compressed instruction with in_last is padded
    push_word(32'h00014515, 4'b0011);
    send(32'h00500513, 1'b1);
    exp_in += 1; exp_comp += 1;
    drain();
    chk("single_count_in", count_in, exp_in);

    // Backpressure: word held stable, input blocked, nothing lost
    push_word(32'h852E4515, 4'b1111);
    push_word(32'h123452B7, 4'b1111);
    send(32'h00500513, 1'b0);
    rdy_mode = 1;
    send(32'h00B00533, 1'b0);
    ifc.in_valid = 1'b1;
    ifc.in_insn  = 32'h123452B7;
    ifc.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(ifc.out_valid), 32'h1);
      chk("bp_out_data", ifc.out_data, 32'h852E4515);
      chk("bp_in_ready", 32'(ifc.in_ready), 32'h0);
    end
    rdy_mode = 0;
    send(32'h123452B7, 1'b1);
    exp_in += 3; exp_comp += 2;
    drain();
    chk("bp_count_in", count_in, exp_in);

    // Asynchronous reset with a held halfword and a stalled output word
    send(32'h00500513, 1'b0);
    rdy_mode = 1;
    send(32'h123452B7, 1'b0);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", 32'(ifc.out_valid), 32'h0);
    chk("arst_out_data", ifc.out_data, 32'h0);
    chk("arst_out_wstrb", 32'(ifc.out_wstrb), 32'h0);
    chk("arst_count_in", count_in, 32'h0);
    chk("arst_count_comp", count_comp, 32'h0);
    rdy_mode = 0;
    exp_in = 0; exp_comp = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    push_word(32'h852E4515, 4'b1111);
    send(32'h00500513, 1'b0);
    send(32'h00B00533, 1'b0);
    exp_in += 2; exp_comp += 2;
    drain();
    chk("post_rst_count_comp", count_comp, exp_comp);

    // Random instructions under random output stalls, checked by expansion
    chk_mode  = 1;
    rdy_mode  = 2;
    have_pend = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      gen(insn, c);
      last = (i == 999) || ($urandom_range(0, 15) == 0);
      pq.push_back({c, insn});
      exp_in += 1;
      if (c) exp_comp += 1;
      send(insn, last);
    end
    drain();
    rdy_mode = 0;
    chk("rand_count_in", count_in, exp_in);
    chk("rand_count_comp", count_comp, exp_comp);
    chk("rand_no_partial", 32'(have_pend), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
